// File: rtl/seq_counter_if.sv
// Control/status bundle for seq_counter. epoch is present only when SEQ_EPOCH_EN is defined.
interface seq_counter_if #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned EPOCH_W = 8
);
  logic             start;
  logic             stop;
  logic             en;
  logic             mode;
  logic             dir;
  logic [WIDTH-1:0] len;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             busy;
  logic             done;
`ifdef SEQ_EPOCH_EN
  logic [EPOCH_W-1:0] epoch;
`endif

  modport master (
    output start, stop, en, mode, dir, len, load, load_val,
    input  count, tc, wrap, busy, done
`ifdef SEQ_EPOCH_EN
    , input epoch
`endif
  );

  modport slave (
    input  start, stop, en, mode, dir, len, load, load_val,
    output count, tc, wrap, busy, done
`ifdef SEQ_EPOCH_EN
    , output epoch
`endif
  );
endinterface

// File: rtl/seq_counter.sv
// Programmable-modulus up/down sequencing counter with IDLE/RUN/DONE handshake.
// Define SEQ_EPOCH_EN to add the epoch (wrap count) register and port.
module seq_counter #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned DEFAULT_LEN = 20,
  parameter int unsigned EPOCH_W     = 8
) (
  input logic           clk,
  input logic           rst,
  seq_counter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] new_last;
  logic             at_term;
  logic             running;
  logic             tc;
  logic             wrap;

  // len of 0 wraps to all ones here, giving the full 2^WIDTH range
  assign last     = len_q - WIDTH'(1);
  assign new_last = bus.len - WIDTH'(1);
  assign at_term  = dir_q ? (count_q == '0) : (count_q == last);
  assign running  = (state_q == StRun);
  assign tc       = running && at_term;
  assign wrap     = tc && bus.en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    mode_d  = mode_q;
    dir_d   = dir_q;

    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.start) begin
      len_d   = bus.len;
      mode_d  = bus.mode;
      dir_d   = bus.dir;
      count_d = bus.dir ? new_last : '0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          if (bus.load) begin
            count_d = (bus.load_val > last) ? last : bus.load_val;
          end else if (bus.en) begin
            if (!at_term) begin
              count_d = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end else if (!mode_q) begin
              count_d = dir_q ? last : '0;
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      len_q   <= WIDTH'(DEFAULT_LEN);
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

`ifdef SEQ_EPOCH_EN
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  // an accepted start clears epoch even if a wrap coincides with it
  always_comb begin
    epoch_d = epoch_q;
    if (!bus.stop && bus.start) begin
      epoch_d = '0;
    end else if (wrap) begin
      epoch_d = epoch_q + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_q <= '0;
    end else begin
      epoch_q <= epoch_d;
    end
  end

  assign bus.epoch = epoch_q;
`endif

  assign bus.count = count_q;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap;
  assign bus.busy  = running;
  assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_seq_counter.sv
// Directed self-checking bench for seq_counter (WIDTH=5, DEFAULT_LEN=20).
module tb_seq_counter;

  localparam int unsigned WIDTH   = 5;
  localparam int unsigned EPOCH_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_cnt;

  seq_counter_if #(.WIDTH(WIDTH), .EPOCH_W(EPOCH_W)) bus ();

  seq_counter #(
    .WIDTH      (WIDTH),
    .DEFAULT_LEN(20),
    .EPOCH_W    (EPOCH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] l, input logic d, input logic m);
    bus.len   = l;
    bus.dir   = d;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.dir   = 1'b0;
    bus.len   = '0;
    bus.load  = 1'b0;
    bus.load_val = '0;
    #12;
    check("rst_count", bus.count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tc", bus.tc, 0);
    check("rst_wrap", bus.wrap, 0);
    rst = 1'b0;
    tick();

    // L=20 up continuous, three passes
    bus.en = 1'b1;
    do_start(5'd20, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        check("l20_count", bus.count, i);
        check("l20_wrap", bus.wrap, (i == 19) ? 1 : 0);
        check("l20_busy", bus.busy, 1);
        if (i == 19) check("l20_tc", bus.tc, 1);
        tick();
      end
    end
    check("l20_after", bus.count, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy", bus.busy, 0);

    // L=5 down one-shot
    do_start(5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("l5_count", bus.count, 4 - i);
      check("l5_wrap", bus.wrap, (i == 4) ? 1 : 0);
      tick();
    end
    check("l5_done", bus.done, 1);
    check("l5_done_busy", bus.busy, 0);
    check("l5_done_count", bus.count, 0);
    check("l5_done_tc", bus.tc, 0);
    tick();
    check("l5_idle_done", bus.done, 0);
    check("l5_idle_busy", bus.busy, 0);
    check("l5_idle_count", bus.count, 0);

    // L=8 up continuous, en toggling
    do_start(5'd8, 1'b0, 1'b0);
    exp_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      bus.en = (k % 2 == 0);
      #1;
      check("l8_count", bus.count, exp_cnt);
      check("l8_wrap", bus.wrap, (exp_cnt == 7 && bus.en) ? 1 : 0);
      tick();
      if (k % 2 == 0) exp_cnt = (exp_cnt == 7) ? 0 : exp_cnt + 1;
    end
    check("l8_final", bus.count, 0);

    // Mid-run loads and stop beating load
    bus.en = 1'b1;
    do_start(5'd20, 1'b0, 1'b0);
    repeat (5) tick();
    check("ld_pre", bus.count, 5);
    bus.load = 1'b1;
    bus.load_val = 5'd30;
    tick();
    bus.en = 1'b0;
    check("ld_clamp", bus.count, 19);
    bus.load_val = 5'd3;
    tick();
    check("ld_3", bus.count, 3);
    bus.load_val = 5'd10;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.load = 1'b0;
    check("ld_stop_count", bus.count, 3);
    check("ld_stop_busy", bus.busy, 0);

    // L=0 is the full 32-state range
    bus.en = 1'b1;
    do_start(5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      check("l0_count", bus.count, i);
      check("l0_wrap", bus.wrap, (i == 31) ? 1 : 0);
      tick();
    end
    check("l0_after", bus.count, 0);

    // L=1 wraps every cycle
    do_start(5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("l1_count", bus.count, 0);
      check("l1_wrap", bus.wrap, 1);
      check("l1_tc", bus.tc, 1);
      tick();
    end

    // Async reset mid-run at count 12
    do_start(5'd20, 1'b0, 1'b0);
    repeat (12) tick();
    check("rr_pre", bus.count, 12);
    rst = 1'b1;
    #1;
    check("rr_count", bus.count, 0);
    check("rr_busy", bus.busy, 0);
    check("rr_tc", bus.tc, 0);
    check("rr_wrap", bus.wrap, 0);
    check("rr_done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef SEQ_EPOCH_EN
    check("ep_rst", bus.epoch, 0);
    do_start(5'd4, 1'b0, 1'b0);
    repeat (12) tick();
    check("ep_three", bus.epoch, 3);
    do_start(5'd4, 1'b0, 1'b0);
    check("ep_clear", bus.epoch, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
Name: seq_counter

Overview:
- Programmable-modulus sequencing counter; parametrised successor of the fixed-length mod-N counter.
- Drives iteration/epoch sequencing in the neural-crypto datapath, e.g. hidden-unit index and synchronisation rounds.
- Adds a runtime length, up/down direction, continuous or one-shot mode, start/stop control and a mid-run load.
- A small state machine (IDLE/RUN/DONE) provides busy/done handshaking to the controlling FSM.

Parameters:
- WIDTH, 5: count width in bits.
- DEFAULT_LEN, 20: length value held in len_q after reset. Must fit in WIDTH bits.
- EPOCH_W, 8: epoch counter width. Used only with SEQ_EPOCH_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a counting run (1-cycle pulse).
- stop  in  1  abort the run and return to IDLE.
- en  in  1  count enable; step only when 1.
- mode  in  1  0 = continuous (wrap forever), 1 = one-shot (single pass).
- dir  in  1  0 = up, 1 = down. Sampled at start.
- len  in  WIDTH  modulus L, sampled at start. Range is 0..L-1; L=0 means 2^WIDTH.
- load  in  1  synchronous load of load_val; honoured in RUN only.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count: busy and count at terminal value (combinational from registers).
- wrap  out  1  tc & en & state==RUN; marks the cycle of the terminal step.
- busy  out  1  1 in RUN.
- done  out  1  1 for exactly one cycle, in DONE.
- epoch  out  EPOCH_W  wrap count. Present only with SEQ_EPOCH_EN.

Behaviour:
- Reset (async, immediate): count=0, state=IDLE, busy=0, done=0, len_q=DEFAULT_LEN, mode_q=0, dir_q=0, epoch=0.
- last = len_q - 1, modulo 2^WIDTH, so L=0 gives last = all ones.
- Terminal value: up = last; down = 0.
- Priority within a cycle: stop > start > load > count step.
- IDLE:
  - count holds; tc=0; wrap=0.
  - On start: latch len_q<=len, mode_q<=mode, dir_q<=dir; count<=0 (up) or last-of-new-len (down); go to RUN next cycle.
  - load is ignored.
- RUN:
  - stop: go to IDLE, count holds.
  - start: restart exactly as from IDLE, re-latching len, mode and dir.
  - load: count<=load_val. If load_val>last, count<=last instead. No step that cycle.
  - en=1, not at terminal: count ±1.
  - en=1, at terminal, mode_q=0: count<=0 (up) or last (down). Stay in RUN.
  - en=1, at terminal, mode_q=1: count holds the terminal value; go to DONE.
  - en=0: count holds.
- DONE: done=1, busy=0 for one cycle, then IDLE. count holds. A start in DONE behaves as a start from IDLE. stop forces IDLE.
- L=1: last=0, so tc=1 every RUN cycle. With en=1, wrap fires every cycle and count stays 0.
- Latency: start → busy=1 the next cycle, count at its initial value. Each step takes 1 cycle.
- No arithmetic overflow: wrap-around is explicit, never by natural rollover, except when L=0 (full range).
- Reset mid-run aborts immediately to the reset values.

Optional Feature:
- Macro SEQ_EPOCH_EN.
- Defined:
  - epoch port and register present; epoch increments on every cycle with wrap=1, including the one-shot terminal step.
  - epoch clears on reset and on an accepted start, and rolls over naturally at 2^EPOCH_W.
- Undefined: no epoch port or logic. All other behaviour is identical.

Test Plan:
- Reset then start, L=20, up, continuous, en=1: count 0..19 with tc/wrap at 19, then 0. busy=1 throughout. Repeats for 3 passes.
- L=5, down, one-shot: count 4,3,2,1,0. wrap at 0, then done=1 for one cycle, then IDLE with count=0 and busy=0.
- L=8, up, en toggled 1/0: count advances only on en=1 cycles. wrap asserts only when count=7 and en=1.
- Mid-run load_val=30 with L=20: count=19 next cycle. load_val=3: count=3. Same cycle as stop: stop wins → IDLE, count held.
- L=0, WIDTH=5, up: count 0..31, wrap at 31, then 0. L=1: count stays 0, wrap every cycle.
- Assert rst in RUN at count=12: all outputs return to reset values immediately. With SEQ_EPOCH_EN: after 3 wraps at L=4, epoch=3; a new start clears epoch to 0.
